// File: rtl/cpu_types_pkg.sv
// Shared memory-controller types: RAM handshake state reported by the RAM model.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/ram_port_scheduler.sv
// Single RAM port arbiter: coherent data requests win by default, per-core
// instruction fetches rotate round-robin, and a data streak limit bounds fetch starvation.
module ram_port_scheduler
  import cpu_types_pkg::*;
#(
  parameter int unsigned CPUS        = 2,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                dREN,
  input  logic                dWEN,
  input  logic [31:0]         daddr,
  input  logic [31:0]         dstore,
  output logic                dwait,
  output logic [31:0]         dload,
  input  logic [CPUS-1:0]     iREN,
  input  logic [32*CPUS-1:0]  iaddr,
  output logic [CPUS-1:0]     iwait,
  output logic [31:0]         iload,
  output logic                ramREN,
  output logic                ramWEN,
  output logic [31:0]         ramaddr,
  output logic [31:0]         ramstore,
  input  logic [31:0]         ramload,
  input  ramstate_t           ramstate
);

  localparam int unsigned OW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int unsigned SW = OW + 1;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 32;
  localparam logic [DW-1:0] DSTREAK_MAX = DW'(MAX_DSTREAK);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT_D = 2'd1;
  localparam logic [1:0] S_GRANT_I = 2'd2;

  logic [1:0]    state_q,   state_d;
  logic [OW-1:0] owner_q,   owner_d;
  logic [OW-1:0] rr_q,      rr_d;
  logic [DW-1:0] dstreak_q, dstreak_d;
  logic          ren_q,     ren_d;
  logic          wen_q,     wen_d;
  logic [AW-1:0] addr_q,    addr_d;
  logic [AW-1:0] wdata_q,   wdata_d;

  logic            any_i;
  logic            d_req;
  logic            i_wins;
  logic            done;
  logic [CPUS-1:0] rot;
  logic [SW-1:0]   sum;
  logic [OW-1:0]   pick_idx;
  logic [OW-1:0]   rr_nxt;
  logic [AW-1:0]   pick_addr;

  assign any_i  = |iREN;
  assign d_req  = dREN | dWEN;
  assign i_wins = any_i && (!d_req || (dstreak_q == DSTREAK_MAX));
  assign done   = (ramstate == ACCESS);

  // Rotate requests so bit 0 is the core at rr; lowest set bit is the winner.
  always_comb begin
    rot      = CPUS'({iREN, iREN} >> rr_q);
    sum      = '0;
    pick_idx = '0;
    for (int i = int'(CPUS) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, rr_q} + SW'(i);
        if (sum >= SW'(CPUS)) sum = sum - SW'(CPUS);
        pick_idx = sum[OW-1:0];
      end
    end
    rr_nxt = (pick_idx == OW'(CPUS - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_comb begin
    pick_addr = '0;
    for (int k = 0; k < int'(CPUS); k++) begin
      if (pick_idx == OW'(k)) pick_addr = iaddr[32*k +: 32];
    end
  end

  // Arbitration and grant-hold next-state logic.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    dstreak_d = dstreak_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_wins) begin
          state_d   = S_GRANT_I;
          owner_d   = pick_idx;
          rr_d      = rr_nxt;
          dstreak_d = '0;
          ren_d     = 1'b1;
          wen_d     = 1'b0;
          addr_d    = pick_addr;
        end else if (d_req) begin
          state_d = S_GRANT_D;
          ren_d   = ~dWEN;
          wen_d   = dWEN;
          addr_d  = daddr;
          if (dWEN) wdata_d = dstore;
          if (any_i) begin
            dstreak_d = (dstreak_q == {DW{1'b1}}) ? dstreak_q : dstreak_q + 4'd1;
          end else begin
            dstreak_d = '0;
          end
        end
      end
      S_GRANT_D, S_GRANT_I: begin
        if (done) begin
          state_d = S_IDLE;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        ren_d   = 1'b0;
        wen_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_q      <= '0;
      dstreak_q <= '0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      dstreak_q <= dstreak_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = wdata_q;
  assign dload    = ramload;
  assign iload    = ramload;
  assign dwait    = ~((state_q == S_GRANT_D) && done);

  // Release only the granted core, and only in the ACCESS cycle.
  always_comb begin
    iwait = '1;
    for (int k = 0; k < int'(CPUS); k++) begin
      if ((state_q == S_GRANT_I) && done && (owner_q == OW'(k))) iwait[k] = 1'b0;
    end
  end

endmodule
